ptw_mem_arbiter: RTL and testbench

//  Memory-side port for the page-table walkers. Arbitrates PTE fetch requests from the I-side and
//  D-side MMU PTW ports onto one Wishbone-classic read master, then returns the PTE word plus a
//  1-cycle ack to the winner. Bus errors/timeouts return PTE 0x0 (V=0), so the MMU raises a page fault.

---
 rtl/ptw_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter.sv
// Arbitrates I-side and D-side page-table-walker PTE fetches onto one Wishbone-classic read master.
// Optional PTE address window check when PTW_ADDR_CHECK_EN is defined.
module ptw_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] PT_BASE        = 32'h8000_0000,
  parameter logic [31:0] PT_LIMIT       = 32'h8040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ptw_req,
  input  logic [31:0] i_ptw_addr,
  output logic [31:0] i_ptw_data,
  output logic        i_ptw_ack,
  input  logic        d_ptw_req,
  input  logic [31:0] d_ptw_addr,
  output logic [31:0] d_ptw_data,
  output logic        d_ptw_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        ptw_bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Reject parameter sets the 8-bit counter or the PTE window cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..256");
  end
  if (PT_LIMIT <= PT_BASE) begin : g_bad_window
    $error("PT_LIMIT must be above PT_BASE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          grant_d, grant_d_next;
  logic          rr_last_d, rr_last_d_next;
  logic          aborted, aborted_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [AW-1:0] adr_next;
  logic          cyc_next, i_ack_next, d_ack_next, bus_err_next;
  logic [DW-1:0] i_data_next, d_data_next;

  logic          pick_d, granted_req, respond, resp_d, resp_err;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] resp_data;

  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_d     <= 1'b0;
      rr_last_d   <= 1'b1;
      aborted     <= 1'b0;
      cnt         <= '0;
      wb_adr_o    <= '0;
      wb_cyc_o    <= 1'b0;
      i_ptw_ack   <= 1'b0;
      d_ptw_ack   <= 1'b0;
      i_ptw_data  <= '0;
      d_ptw_data  <= '0;
      ptw_bus_err <= 1'b0;
    end else begin
      state       <= state_next;
      grant_d     <= grant_d_next;
      rr_last_d   <= rr_last_d_next;
      aborted     <= aborted_next;
      cnt         <= cnt_next;
      wb_adr_o    <= adr_next;
      wb_cyc_o    <= cyc_next;
      i_ptw_ack   <= i_ack_next;
      d_ptw_ack   <= d_ack_next;
      i_ptw_data  <= i_data_next;
      d_ptw_data  <= d_data_next;
      ptw_bus_err <= bus_err_next;
    end
  end

  // Next state plus next values of every registered output; acks are set on the edge entering RESP.
  always_comb begin
    state_next     = state;
    grant_d_next   = grant_d;
    rr_last_d_next = rr_last_d;
    aborted_next   = aborted;
    cnt_next       = cnt;
    adr_next       = wb_adr_o;
    cyc_next       = wb_cyc_o;
    i_ack_next     = 1'b0;
    d_ack_next     = 1'b0;
    bus_err_next   = 1'b0;
    i_data_next    = i_ptw_data;
    d_data_next    = d_ptw_data;
    respond        = 1'b0;
    resp_d         = grant_d;
    resp_err       = 1'b0;
    resp_data      = '0;

    // On a tie the side that was not served last wins.
    pick_d      = d_ptw_req & (~i_ptw_req | ~rr_last_d);
    pick_addr   = pick_d ? d_ptw_addr : i_ptw_addr;
    granted_req = grant_d ? d_ptw_req : i_ptw_req;

    case (state)
      S_IDLE: begin
        if (i_ptw_req | d_ptw_req) begin
          grant_d_next = pick_d;
          adr_next     = pick_addr;
          aborted_next = 1'b0;
          cnt_next     = '0;
          resp_d       = pick_d;
`ifdef PTW_ADDR_CHECK_EN
          if (pick_addr < PT_BASE || pick_addr >= PT_LIMIT) begin
            state_next = S_RESP;
            respond    = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next = S_BUS;
            cyc_next   = 1'b1;
          end
`else
          state_next = S_BUS;
          cyc_next   = 1'b1;
`endif
        end
      end
      S_BUS: begin
        cnt_next = cnt + CW'(1);
        if (!granted_req) aborted_next = 1'b1;
        // A dropped request still lets the bus cycle finish, but gets no response.
        if (wb_ack_i) begin
          state_next = S_RESP;
          cyc_next   = 1'b0;
          respond    = ~aborted & granted_req;
          resp_data  = wb_dat_i;
        end else if (wb_err_i || cnt == CNT_LAST) begin
          state_next = S_RESP;
          cyc_next   = 1'b0;
          respond    = ~aborted & granted_req;
          resp_err   = 1'b1;
        end
      end
      S_RESP: begin
        rr_last_d_next = grant_d;
        cnt_next       = '0;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (respond) begin
      bus_err_next = resp_err;
      if (resp_d) begin
        d_ack_next  = 1'b1;
        d_data_next = resp_data;
      end else begin
        i_ack_next  = 1'b1;
        i_data_next = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: vector table, scoreboard of expected acks, corner sequences.
module tb_ptw_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [31:0] i_ptw_data, d_ptw_data;
  logic        i_ptw_ack, d_ptw_ack;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, ptw_bus_err;

  // Slave model: mode 0 = silent, 1 = ack, 2 = err, after slv_wait wait states.
  int          slv_mode = 0;
  int          slv_wait = 0;
  logic [31:0] slv_data = '0;
  int          slv_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) slv_cnt <= wb_cyc_o ? slv_cnt + 1 : 0;

  assign wb_ack_i = wb_cyc_o && slv_mode == 1 && slv_cnt == slv_wait;
  assign wb_err_i = wb_cyc_o && slv_mode == 2 && slv_cnt == slv_wait;
  assign wb_dat_i = wb_ack_i ? slv_data : 32'hDEAD_BEEF;

  ptw_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ptw_req(i_req), .i_ptw_addr(i_addr), .i_ptw_data(i_ptw_data), .i_ptw_ack(i_ptw_ack),
    .d_ptw_req(d_req), .d_ptw_addr(d_addr), .d_ptw_data(d_ptw_data), .d_ptw_ack(d_ptw_ack),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .ptw_bus_err(ptw_bus_err)
  );

  typedef struct {
    bit          side_d;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } sb_t;

  typedef struct {
    bit          i_req;
    bit          d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] data;
    int          mode;
    int          waits;
    bit          d_first;
    bit          err;
    int          len;
  } vec_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   last_len = 0;
  int   cyc_total = 0;
  logic snap_cyc, snap_iack, snap_dack;
  logic [31:0] snap_adr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit side_d, input logic [31:0] addr, input logic [31:0] data,
                      input bit err);
    sb_t e;
    e.side_d = side_d;
    e.addr   = addr;
    e.data   = err ? 32'h0 : data;
    e.err    = err;
    sb.push_back(e);
  endtask

  // One clock: sample and score at negedge, then drop any request whose ack was seen.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    snap_cyc  = wb_cyc_o;
    snap_adr  = wb_adr_o;
    snap_iack = i_ptw_ack;
    snap_dack = d_ptw_ack;
    if (rst_n) begin
      if (i_ptw_ack || d_ptw_ack || ptw_bus_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {29'b0, ptw_bus_err, d_ptw_ack, i_ptw_ack}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ack_side", {30'b0, d_ptw_ack, i_ptw_ack}, e.side_d ? 32'h2 : 32'h1);
          chk("ack_data", e.side_d ? d_ptw_data : i_ptw_data, e.data);
          chk("bus_err", {31'b0, ptw_bus_err}, {31'b0, e.err});
        end
      end
      if (wb_cyc_o) begin
        chk("wb_ctrl", {26'b0, wb_stb_o, wb_we_o, wb_sel_o}, 32'h2F);
        if (sb.size() != 0) chk("wb_adr", wb_adr_o, sb[0].addr);
        run_len++;
        cyc_total++;
      end else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
    end
    @(posedge clk);
    #1;
    if (snap_iack) i_req = 1'b0;
    if (snap_dack) d_req = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    int budget;
    slv_mode = v.mode;
    slv_wait = v.waits;
    slv_data = v.data;
    i_addr   = v.i_addr;
    d_addr   = v.d_addr;
    if (v.i_req && v.d_req) begin
      push(v.d_first, v.d_first ? v.d_addr : v.i_addr, v.data, v.err);
      push(!v.d_first, v.d_first ? v.i_addr : v.d_addr, v.data, v.err);
    end else begin
      push(v.d_req, v.d_req ? v.d_addr : v.i_addr, v.data, v.err);
    end
    i_req = v.i_req;
    d_req = v.d_req;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    if (sb.size() != 0) begin
      chk("ack_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
      i_req = 1'b0;
      d_req = 1'b0;
    end
    tick();
    chk("bus_len", 32'(last_len), 32'(v.len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   n_ack;
    int   c0;
    logic [31:0] bad_addr[3];

    //            i  d  i_addr        d_addr        data          mode wait dfirst err len
    vecs[0] = '{1, 1, 32'h8000_1000, 32'h8000_2000, 32'h1234_5671, 1, 0, 0, 0, 1};
    vecs[1] = '{1, 1, 32'h8000_1004, 32'h8000_2004, 32'h0BAD_F00D, 1, 1, 0, 0, 2};
    vecs[2] = '{1, 1, 32'h8000_1008, 32'h8000_2008, 32'h7777_0003, 1, 2, 0, 0, 3};
    vecs[3] = '{1, 0, 32'h8000_0004, 32'h0,         32'h2004_00FF, 1, 0, 0, 0, 1};
    vecs[4] = '{0, 1, 32'h0,         32'h8000_3000, 32'h5A5A_5A5A, 2, 2, 0, 1, 3};
    vecs[5] = '{1, 0, 32'h8000_0FFC, 32'h0,         32'hCAFE_0001, 1, 3, 0, 0, 4};
    vecs[6] = '{0, 1, 32'h0,         32'h8000_3FFC, 32'h1111_2222, 0, 0, 0, 1, 8};
    vecs[7] = '{0, 1, 32'h0,         32'h8000_3004, 32'h0000_00AB, 1, 0, 0, 0, 1};
    vecs[8] = '{1, 1, 32'h8000_1010, 32'h8000_2010, 32'h600D_0008, 1, 0, 0, 0, 1};

    rst_n  = 1'b0;
    i_req  = 1'b0;
    d_req  = 1'b0;
    i_addr = '0;
    d_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("rst_acks", {30'b0, d_ptw_ack, i_ptw_ack}, 32'h0);
    chk("rst_i_data", i_ptw_data, 32'h0);
    chk("rst_d_data", d_ptw_data, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_bus_err", {31'b0, ptw_bus_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) apply_vec(vecs[k]);

    // First-fetch latency: bus in cycle 1, requester ack in cycle 2.
    slv_mode = 1; slv_wait = 0; slv_data = 32'h2004_00FF;
    i_addr = 32'h8000_0004;
    push(1'b0, 32'h8000_0004, 32'h2004_00FF, 1'b0);
    i_req = 1'b1;
    tick();
    chk("lat_c0_cyc", {31'b0, snap_cyc}, 32'h0);
    tick();
    chk("lat_c1_cyc", {31'b0, snap_cyc}, 32'h1);
    chk("lat_c1_adr", snap_adr, 32'h8000_0004);
    tick();
    chk("lat_c2_acks", {30'b0, snap_dack, snap_iack}, 32'h1);
    tick();

    // D drops its request mid-bus: cycle completes, no ack, but D counts as last served.
    slv_mode = 1; slv_wait = 4; slv_data = 32'h5555_AAAA;
    d_addr = 32'h8000_2100;
    d_req = 1'b1;
    tick();
    tick();
    d_req = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (snap_iack || snap_dack) n_ack++;
    end
    chk("abort_no_ack", 32'(n_ack), 32'h0);
    chk("abort_bus_len", 32'(last_len), 32'h5);
    v = '{1, 1, 32'h8000_1020, 32'h8000_2020, 32'h0101_0101, 1, 0, 0, 0, 1};
    apply_vec(v);

    // Reset in the middle of a stalled bus cycle.
    slv_mode = 0;
    i_addr = 32'h8000_0100;
    i_req = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("midrst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("midrst_acks", {29'b0, ptw_bus_err, d_ptw_ack, i_ptw_ack}, 32'h0);
    chk("midrst_i_data", i_ptw_data, 32'h0);
    chk("midrst_adr", wb_adr_o, 32'h0);
    i_req = 1'b0;
    run_len = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (snap_iack || snap_dack) n_ack++;
    end
    chk("midrst_no_ack", 32'(n_ack), 32'h0);
    v = '{1, 1, 32'h8000_0040, 32'h8000_0044, 32'h4242_4242, 1, 1, 0, 0, 2};
    apply_vec(v);

`ifdef PTW_ADDR_CHECK_EN
    bad_addr[0] = 32'h9000_0000;
    bad_addr[1] = 32'h8040_0000;
    bad_addr[2] = 32'h7FFF_FFFC;
    for (int k = 0; k < 3; k++) begin
      c0 = cyc_total;
      i_addr = bad_addr[k];
      push(1'b0, bad_addr[k], 32'h0, 1'b1);
      i_req = 1'b1;
      tick();
      chk("range_c0_ack", {31'b0, snap_iack}, 32'h0);
      tick();
      chk("range_c1_ack", {31'b0, snap_iack}, 32'h1);
      tick();
      chk("range_no_cyc", 32'(cyc_total - c0), 32'h0);
    end
    v = '{1, 0, 32'h803F_FFFC, 32'h0, 32'h3F3F_0001, 1, 0, 0, 0, 1};
    apply_vec(v);
`else
    bad_addr[0] = 32'h0;
    c0 = 0;
    if (bad_addr[0] != 32'(c0)) $display("bad_addr unused");
`endif

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
